serial_adder: RTL and testbench
===============================

# serial_adder

Bit-serial adder that wraps one `full_adder` cell with a carry flop and shift registers. It accepts a parallel operand pair plus carry-in over a valid/ready handshake, then computes one sum bit per clock, LSB first. It returns the parallel sum and carry-out over a second valid/ready handshake. It is the sequential consumer of the `full_adder` cell and trades WIDTH cycles of latency for a single adder cell.

## Interface
- `WIDTH`, default 8: operand width in bits; legal range is WIDTH >= 1.

Ports (name, direction, width, meaning):
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous, active-high.
- `in_valid` input 1: operands are present on `a`, `b`, `cin`.
- `in_ready` output 1: block can accept operands.
- `a` input WIDTH: operand A.
- `b` input WIDTH: operand B.
- `cin` input 1: carry into bit 0.
- `out_valid` output 1: `sum` and `cout` hold a result.
- `out_ready` input 1: downstream accepts the result.
- `sum` output WIDTH: (a + b + cin) mod 2^WIDTH.
- `cout` output 1: bit WIDTH of a + b + cin.

## Operation
- FSM states:
  - IDLE: `in_ready`=1, `out_valid`=0.
  - RUN: both `in_ready` and `out_valid` are 0.
  - DONE: `in_ready`=0, `out_valid`=1.
- `in_ready` and `out_valid` are decoded from the state register only. They have no combinational path from inputs.
- IDLE → RUN on `in_valid && in_ready`. At that edge:
  - latch `a` and `b` into shift registers SA and SB;
  - latch `cin` into the carry flop;
  - clear the bit counter;
  - clear the sum shift register.
- RUN, each edge:
  - one `full_adder` instance sees SA[0], SB[0] and the carry flop;
  - its sum bit shifts into the MSB of the sum register, and the register shifts right;
  - SA and SB shift right;
  - the carry flop takes the cell's `cout`;
  - the counter increments.
- RUN → DONE on the edge that processes bit WIDTH-1. At that edge `cout` is loaded from the final carry.
- DONE → IDLE on `out_valid && out_ready`.
- While in DONE, `sum` and `cout` stay stable until the handshake completes, whatever `out_ready` does.
- `in_valid` is ignored outside IDLE. The `a`, `b` and `cin` inputs are don't-care outside the accept edge.
- Bit counter width is $clog2(WIDTH+1). It never wraps past WIDTH-1.
- WIDTH=1: RUN lasts exactly one cycle.
- Reset values:
  - state = IDLE, so `in_ready`=1 from the first cycle after reset;
  - `out_valid`=0;
  - `sum`=0;
  - `cout`=0;
  - carry flop, counter, SA and SB = 0.
- Reset asserted in RUN or DONE aborts the operation. The in-flight result is discarded and no `out_valid` pulse appears.
- Reset has priority over every handshake in the same cycle.

## Timing
- Accept edge E0, where `in_valid && in_ready` is high.
- RUN occupies the cycles between E0 and E_WIDTH.
- `out_valid` rises in the cycle after edge E_WIDTH, which is WIDTH clocks after acceptance.
- Minimum cycle time per operation is WIDTH+2 clocks (1 IDLE, WIDTH RUN, 1 DONE with `out_ready` held high).
- There is no bypass: `in_ready` reasserts the cycle after the output handshake edge, never in the same cycle.
- `sum` and `cout` change only at E0 (cleared) and during RUN. They are guaranteed valid only while `out_valid`=1.

## Test plan
All scenarios use WIDTH=8 unless stated.
- **Reset:** hold `rst` 2 cycles → `in_ready`=1, `out_valid`=0, `sum`=0x00, `cout`=0 on the first post-reset cycle.
- **Basic add:** `a`=0x12, `b`=0x34, `cin`=0, `out_ready`=1 → `out_valid` 8 clocks after accept with `sum`=0x46, `cout`=0; `in_ready` high again the following cycle.
- **Carry ripple:**
  - `a`=0xFF, `b`=0x01, `cin`=0 → `sum`=0x00, `cout`=1;
  - `a`=0xA5, `b`=0x5A, `cin`=1 → `sum`=0x00, `cout`=1;
  - `a`=0xFF, `b`=0xFF, `cin`=1 → `sum`=0xFF, `cout`=1.
- **Backpressure:** hold `out_ready`=0 for 5 cycles after `out_valid` rises → `out_valid`, `sum` and `cout` stay constant and `in_ready` stays 0. Then `out_ready`=1 for one cycle → `out_valid`=0 and `in_ready`=1 on the next cycle.
- **Ignored input and abort:**
  - pulse `in_valid` with new operands during RUN → result still matches the originally accepted operands;
  - assert `rst` at RUN bit 4 → `out_valid` never asserts, and the next accepted op `a`=0x01, `b`=0x01, `cin`=0 gives `sum`=0x02, `cout`=0.
- **Exhaustive, WIDTH=1:** all 8 {a,b,cin} combos back-to-back → `sum`/`cout` match the full-adder truth table (e.g. 1,1,1 → 1,1), with `out_valid` one clock after each accept.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell, a carry flop and shift registers.
// Operands are accepted over a valid/ready handshake and processed LSB first,
// one bit per clock. The parallel sum and carry-out are returned over a second
// valid/ready handshake.

// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] sa_q, sa_d;
    logic [WIDTH-1:0] sb_q, sb_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] sum_shifted;

    // The single adder cell always looks at the LSBs and the running carry.
    full_adder u_fa (
        .a  (sa_q[0]),
        .b  (sb_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    // New sum bit enters at the MSB so that after WIDTH shifts bit 0 lands at
    // position 0. A one-bit register has nothing to shift, so it just loads.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign sum_shifted = fa_s;
        end else begin : g_sum_wn
            assign sum_shifted = {fa_s, sum_q[WIDTH-1:1]};
        end
    endgenerate

    // Handshake flags come from the state register only.
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

    // Next-state and datapath: load on accept, shift during RUN, hold in DONE.
    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_RUN;
                    sa_d    = a;
                    sb_d    = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    sum_d   = '0;
                    cout_d  = 1'b0;
                end
            end
            S_RUN: begin
                sa_d    = sa_q >> 1;
                sb_d    = sb_q >> 1;
                sum_d   = sum_shifted;
                carry_d = fa_co;
                if (cnt_q == LAST_BIT) begin
                    // Counter parks at the last bit rather than wrapping.
                    state_d = S_DONE;
                    cout_d  = fa_co;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers; reset wins over any handshake in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: a WIDTH=8 instance for directed and
// random operations, and a WIDTH=1 instance for the full-adder truth table.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst;

    // WIDTH=8 instance signals
    logic       in_valid, in_ready, out_valid, out_ready, cin, cout;
    logic [7:0] a, b, sum;

    // WIDTH=1 instance signals
    logic       in_valid1, in_ready1, out_valid1, out_ready1, cin1, cout1;
    logic [0:0] a1, b1, sum1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    serial_adder #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(out_ready1),
        .sum(sum1), .cout(cout1)
    );

    // Advance one clock, then settle 1 time unit past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer addition, split into sum and carry-out.
    function automatic logic [8:0] ref_add8(input logic [7:0] x, input logic [7:0] y, input logic c);
        int unsigned t;
        t = int'(x) + int'(y) + int'(c);
        return t[8:0];
    endfunction

    // One WIDTH=8 operation with out_ready held high. Optionally drives junk
    // on the inputs (with in_valid high) while the adder is busy.
    task automatic op8(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                       input bit junk, input string tag);
        logic [8:0] exp;
        int n;
        exp = ref_add8(xa, xb, xc);
        n = 0;
        while (!in_ready && n < 50) begin tick(); n++; end
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        out_ready = 1'b1;
        in_valid = 1'b1; a = xa; b = xb; cin = xc;
        tick();
        in_valid = junk;
        n = 0;
        while (!out_valid && n < 50) begin
            if (junk) begin
                a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
            end
            tick();
            n++;
        end
        in_valid = 1'b0;
        chk({tag, "_latency"}, n, 8);
        chk({tag, "_sum"}, sum, exp[7:0]);
        chk({tag, "_cout"}, cout, exp[8]);
        $display("op8 %s a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d latency=%0d",
                 tag, xa, xb, xc, sum, cout, n);
        tick();
        chk({tag, "_ovalid_drop"}, out_valid, 1'b0);
        chk({tag, "_iready_back"}, in_ready, 1'b1);
    endtask

    // One WIDTH=1 operation; returns immediately after the output handshake.
    task automatic op1(input logic xa, input logic xb, input logic xc);
        int n;
        int t;
        t = int'(xa) + int'(xb) + int'(xc);
        n = 0;
        while (!in_ready1 && n < 20) begin tick(); n++; end
        out_ready1 = 1'b1;
        in_valid1 = 1'b1; a1 = xa; b1 = xb; cin1 = xc;
        tick();
        in_valid1 = 1'b0;
        n = 0;
        while (!out_valid1 && n < 20) begin tick(); n++; end
        chk("w1_latency", n, 1);
        chk("w1_sum", sum1, t[0]);
        chk("w1_cout", cout1, t[1]);
        $display("op1 a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d latency=%0d",
                 xa, xb, xc, sum1, cout1, n);
        tick();
    endtask

    initial begin
        logic [8:0] exp;
        logic [7:0] held_sum;
        logic       held_cout;
        int         n;
        bit         seen;

        in_valid = 0; out_ready = 0; a = 0; b = 0; cin = 0;
        in_valid1 = 0; out_ready1 = 0; a1 = 0; b1 = 0; cin1 = 0;

        // Reset held for two cycles.
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_cout", cout, 1'b0);
        chk("rst_w1_in_ready", in_ready1, 1'b1);
        $display("reset in_ready=%0d out_valid=%0d sum=%02h cout=%0d", in_ready, out_valid, sum, cout);

        // Directed adds including carry ripple.
        op8(8'h12, 8'h34, 1'b0, 0, "basic");
        op8(8'hFF, 8'h01, 1'b0, 0, "ripple1");
        op8(8'hA5, 8'h5A, 1'b1, 0, "ripple2");
        op8(8'hFF, 8'hFF, 1'b1, 0, "ripple3");
        op8(8'h00, 8'h00, 1'b0, 0, "zero");

        // In_valid pulsed with fresh operands during RUN is ignored.
        op8(8'h3C, 8'h47, 1'b1, 1, "ignored");

        // Backpressure: result must hold while out_ready is low.
        exp = ref_add8(8'h9E, 8'h73, 1'b0);
        out_ready = 1'b0;
        in_valid = 1'b1; a = 8'h9E; b = 8'h73; cin = 1'b0;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 50) begin tick(); n++; end
        chk("bp_latency", n, 8);
        held_sum = sum; held_cout = cout;
        chk("bp_sum", held_sum, exp[7:0]);
        chk("bp_cout", held_cout, exp[8]);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_ready", in_ready, 1'b0);
            chk("bp_hold_sum", sum, exp[7:0]);
            chk("bp_hold_cout", cout, exp[8]);
        end
        $display("backpressure held sum=%02h cout=%0d for 5 cycles", sum, cout);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_valid", out_valid, 1'b0);
        chk("bp_release_ready", in_ready, 1'b1);

        // Abort: reset arrives at RUN bit 4, no result ever appears.
        out_ready = 1'b1;
        in_valid = 1'b1; a = 8'h77; b = 8'h88; cin = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_busy", in_ready, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            if (out_valid) seen = 1;
            tick();
        end
        chk("abort_no_valid", seen, 1'b0);
        chk("abort_in_ready", in_ready, 1'b1);
        $display("abort out_valid_seen=%0d", seen);
        op8(8'h01, 8'h01, 1'b0, 0, "post_abort");

        // Random operations against the arithmetic model.
        for (int i = 0; i < 20; i++) begin
            op8(8'($urandom), 8'($urandom), 1'($urandom), bit'($urandom_range(0, 1)), "rand");
        end

        // WIDTH=1: full-adder truth table, back to back.
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v = 3'(i);
            op1(v[2], v[1], v[0]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
